// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: N-channel PWM LED driver that cross-fades each channel's duty one LSB at a time.
// Optional gamma-corrected compare value when RGB_PWM_FADER_GAMMA_EN is defined (linear otherwise).
module rgb_pwm_fader #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 47,
  parameter int FADE_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CHANNELS*WIDTH-1:0] cfg_duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      busy,
  output logic                      period_start,
  output logic                      dbg_state
);

  // Handshake: a target word transfers on a clk edge where cfg_valid && cfg_ready are both high;
  // cfg_ready is low for the whole fade, and words offered meanwhile wait until it rises again.

  localparam int PRE_W  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int FADE_W = (FADE_DIV > 0) ? $clog2(FADE_DIV + 1) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE);
  localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
  localparam logic [FADE_W-1:0] FADE_MAX = FADE_W'(FADE_DIV);
  localparam logic [FADE_W-1:0] FADE_ONE = FADE_W'(1);
  localparam logic [WIDTH-1:0]  DUTY_ONE = WIDTH'(1);
`ifdef RGB_PWM_FADER_GAMMA_EN
  localparam int PROD_W = 2 * WIDTH;
  localparam logic [PROD_W-1:0] PROD_ONE = PROD_W'(1);
`endif

  typedef enum logic {IDLE = 1'b0, FADING = 1'b1} state_t;

  state_t                         state_q;
  logic [PRE_W-1:0]               pre_cnt_q;
  logic [WIDTH-1:0]               pwm_cnt_q;
  logic [FADE_W-1:0]              fade_cnt_q;
  logic [CHANNELS-1:0][WIDTH-1:0] cur_q;
  logic [CHANNELS-1:0][WIDTH-1:0] tgt_q;
  logic [CHANNELS-1:0][WIDTH-1:0] cur_d;
  logic [CHANNELS-1:0][WIDTH-1:0] cmp;
  logic [CHANNELS-1:0]            pwm_q;
  logic                           ready_q;
  logic                           busy_q;
  logic                           ps_q;
  logic                           tick;
  logic                           boundary;
  logic                           fade_step;
  logic                           all_eq;

  assign tick      = (pre_cnt_q == PRE_MAX);
  assign boundary  = tick && (pwm_cnt_q == '1);
  assign fade_step = (fade_cnt_q == FADE_MAX);

  // cur_d is the duty set the next period would use if this cycle is a boundary.
  always_comb begin
    cur_d  = cur_q;
    cmp    = '0;
    all_eq = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (fade_step && (cur_q[i] < tgt_q[i])) begin
        cur_d[i] = cur_q[i] + DUTY_ONE;
      end else if (fade_step && (cur_q[i] > tgt_q[i])) begin
        cur_d[i] = cur_q[i] - DUTY_ONE;
      end
      if (cur_d[i] != tgt_q[i]) begin
        all_eq = 1'b0;
      end
`ifdef RGB_PWM_FADER_GAMMA_EN
      cmp[i] = WIDTH'((PROD_W'(cur_q[i]) * (PROD_W'(cur_q[i]) + PROD_ONE)) >> WIDTH);
`else
      cmp[i] = cur_q[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      cur_q      <= '0;
      tgt_q      <= '0;
      pwm_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      pre_cnt_q <= tick ? '0 : pre_cnt_q + PRE_ONE;
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + DUTY_ONE;
      end
      ps_q <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_q[i] <= (pwm_cnt_q < cmp[i]);
      end
      case (state_q)
        IDLE: begin
          // An accept coinciding with a boundary takes no step; the fade begins at the next one.
          if (cfg_valid && ready_q) begin
            tgt_q      <= cfg_duty;
            fade_cnt_q <= '0;
            state_q    <= FADING;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        FADING: begin
          if (boundary) begin
            cur_q      <= cur_d;
            fade_cnt_q <= fade_step ? '0 : fade_cnt_q + FADE_ONE;
            if (all_eq) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready    = ready_q;
  assign busy         = busy_q;
  assign period_start = ps_q;
  assign pwm_out      = pwm_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: a fast 4-bit instance for fade behaviour and an 8-bit prescaled one for timing.
module tb_rgb_pwm_fader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        a_valid, a_ready, a_busy, a_ps, a_dbg;
  logic [11:0] a_duty;
  logic [2:0]  a_pwm;
  logic        b_valid, b_ready, b_busy, b_ps, b_dbg;
  logic [23:0] b_duty;
  logic [2:0]  b_pwm;

  int n_tests = 0;
  int n_fail  = 0;

  // Period-level model of instance A: duty used by the period that just began, and targets.
  int m_cur[3], m_tgt[3], m_pend[3];
  bit m_fading, m_pending, m_skip, drop_pending;

  rgb_pwm_fader #(.CHANNELS(3), .WIDTH(4), .PRESCALE(0), .FADE_DIV(0)) u_a (
    .clk(clk), .rst_n(rst_a_n), .cfg_valid(a_valid), .cfg_ready(a_ready), .cfg_duty(a_duty),
    .pwm_out(a_pwm), .busy(a_busy), .period_start(a_ps), .dbg_state(a_dbg));

  rgb_pwm_fader #(.CHANNELS(3), .WIDTH(8), .PRESCALE(2), .FADE_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_b_n), .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_duty(b_duty),
    .pwm_out(b_pwm), .busy(b_busy), .period_start(b_ps), .dbg_state(b_dbg));

  function automatic int cmp_m(input int d, input int w);
`ifdef RGB_PWM_FADER_GAMMA_EN
    return (d * (d + 1)) >> w;
`else
    return d % (1 << w);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_a();
    @(negedge clk);
    if (drop_pending) begin
      a_valid      = 1'b0;
      drop_pending = 1'b0;
    end
    if (a_valid && a_ready) drop_pending = 1'b1;
  endtask

  task automatic wait_ps_a();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick_a();
      ok = a_ps;
    end
    check("a_period_start_seen", ok, 1);
  endtask

  task automatic align_a(input int off);
    wait_ps_a();
    repeat (off) tick_a();
  endtask

  task automatic send_a(input int d0, input int d1, input int d2, input bit skip);
    a_duty  = {d2[3:0], d1[3:0], d0[3:0]};
    a_valid = 1'b1;
    if (a_ready) drop_pending = 1'b1;
    if (!m_fading) begin
      m_tgt    = '{d0, d1, d2};
      m_fading = 1'b1;
      m_skip   = skip;
    end else begin
      m_pend    = '{d0, d1, d2};
      m_pending = 1'b1;
    end
  endtask

  task automatic run_period_a(input string tag);
    int  h[3];
    bit  done;
    wait_ps_a();
    if (m_skip) begin
      m_skip = 1'b0;
    end else if (m_fading) begin
      done = 1'b1;
      for (int c = 0; c < 3; c++) begin
        if (m_cur[c] < m_tgt[c]) m_cur[c]++;
        else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
        if (m_cur[c] != m_tgt[c]) done = 1'b0;
      end
      if (done) m_fading = 1'b0;
    end
    check({tag, "_busy"}, a_busy, m_fading);
    check({tag, "_ready"}, a_ready, !m_fading);
    check({tag, "_state"}, a_dbg, m_fading);
    h = '{0, 0, 0};
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick_a();
      for (int c = 0; c < 3; c++) h[c] += a_pwm[c];
    end
    for (int c = 0; c < 3; c++) check($sformatf("%s_ch%0d_high", tag, c), h[c], cmp_m(m_cur[c], 4));
    if (!m_fading && m_pending) begin
      m_tgt     = m_pend;
      m_fading  = 1'b1;
      m_pending = 1'b0;
    end
  endtask

  task automatic fade_a(input string tag);
    int n;
    n = 0;
    while ((m_fading || m_pending) && n < 40) begin
      run_period_a(tag);
      n++;
    end
  endtask

  task automatic wait_ps_b();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = b_ps;
    end
    check("b_period_start_seen", ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, steps, r0, r1, r2, off;
    int hb[3], cb[3];
    bit ok;

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_valid = 1'b0; a_duty = '0; b_valid = 1'b0; b_duty = '0;
    m_cur = '{0, 0, 0}; m_tgt = '{0, 0, 0}; m_pend = '{0, 0, 0};
    m_fading = 1'b0; m_pending = 1'b0; m_skip = 1'b0; drop_pending = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_pwm", a_pwm, 0);
    check("rst_busy", a_busy, 0);
    check("rst_ready", a_ready, 1);
    check("rst_ps", a_ps, 0);
    check("rst_b_ready", b_ready, 1);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick_a();
    check("post_rst_ready", a_ready, 1);
    check("post_rst_busy", a_busy, 0);

    // Ramp from reset: ch0 high time 1..10, busy drops with the tenth period.
    align_a(3);
    send_a(10, 0, 0, 1'b0);
    fade_a("ramp10");

    // Cross-fade to max / half / zero.
    align_a(5);
    send_a(0, 8, 15, 1'b0);
    fade_a("xfade");

    align_a(2);
    send_a(1, 8, 15, 1'b0);
    fade_a("levels");
    run_period_a("levels_hold");

    // New word while busy is held off until the fade completes.
    align_a(4);
    send_a(5, 5, 5, 1'b0);
    run_period_a("hold");
    run_period_a("hold");
    send_a(12, 3, 7, 1'b0);
    check("hold_ready_low", a_ready, 0);
    fade_a("hold");

    // Same targets as current: one FADING boundary then idle.
    align_a(6);
    send_a(12, 3, 7, 1'b0);
    fade_a("equal");

    // Accept on the boundary edge: that boundary does not step.
    align_a(15);
    send_a(0, 0, 0, 1'b1);
    fade_a("skip");

    for (int r = 0; r < 6; r++) begin
      off = $urandom_range(1, 15);
      r0 = $urandom_range(0, 15); r1 = $urandom_range(0, 15); r2 = $urandom_range(0, 15);
      align_a(off);
      send_a(r0, r1, r2, off == 15);
      run_period_a("rand");
      if ($urandom_range(0, 1) == 1) begin
        r0 = $urandom_range(0, 15); r1 = $urandom_range(0, 15); r2 = $urandom_range(0, 15);
        send_a(r0, r1, r2, !m_fading);
      end
      fade_a("rand");
    end

    // Asynchronous reset in the middle of a fade.
    align_a(1);
    send_a(15, 15, 15, 1'b0);
    run_period_a("prereset");
    run_period_a("prereset");
    run_period_a("prereset");
    tick_a();
    tick_a();
    check("prereset_pwm_on", a_pwm, 3'b111);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("async_rst_pwm", a_pwm, 0);
    check("async_rst_busy", a_busy, 0);
    check("async_rst_ready", a_ready, 1);
    check("async_rst_ps", a_ps, 0);
    check("async_rst_state", a_dbg, 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    a_valid = 1'b0;
    m_cur = '{0, 0, 0}; m_tgt = '{0, 0, 0};
    m_fading = 1'b0; m_pending = 1'b0; m_skip = 1'b0; drop_pending = 1'b0;
    run_period_a("post_reset");
    align_a(3);
    send_a(2, 2, 2, 1'b0);
    fade_a("post_reset_fade");

    // Instance B: PRESCALE=2 gives 768-clk periods; FADE_DIV=1 steps every second boundary.
    for (int s = 0; s < 2; s++) begin
      wait_ps_b();
      n = 0; ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
        @(negedge clk);
        n++;
        ok = b_ps;
      end
      check("b_spacing", n, 768);
    end
    repeat (5) @(negedge clk);
    check("b_ready_idle", b_ready, 1);
    b_duty  = {8'd0, 8'd2, 8'd3};
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    check("b_busy_after_accept", b_busy, 1);
    check("b_ready_after_accept", b_ready, 0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) wait_ps_b();
      else begin
        @(negedge clk);
        check("b_period_spacing", b_ps, 1);
      end
      steps = k / 2;
      cb[0] = (steps < 3) ? steps : 3;
      cb[1] = (steps < 2) ? steps : 2;
      cb[2] = 0;
      check($sformatf("b_busy_k%0d", k), b_busy, k < 6);
      hb = '{0, 0, 0};
      for (int i = 0; i < 768; i++) begin
        if (i > 0) @(negedge clk);
        for (int c = 0; c < 3; c++) hb[c] += b_pwm[c];
      end
      for (int c = 0; c < 3; c++)
        check($sformatf("b_k%0d_ch%0d_high", k, c), hb[c], 3 * cmp_m(cb[c], 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
